// File: rtl/doodle_pkg.sv
// Shared types and game-state encodings for the doodle game-view renderers.
package doodle_pkg;

    localparam logic [1:0] GS_MENU = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_OVER = 2'd2;

    // Glyph-local row/column coordinate width
    localparam int unsigned GLYPH_COORD_W = 6;

    typedef logic [2:0][3:0] rgb444_t;
    typedef logic [3:0]      bcd_digit_t;

endpackage

// File: rtl/digit_glyph_rom.sv
// Seven-segment style digit glyphs, 13x12, white on transparent.
// Registered output; alpha also folds in the caller's visibility mask.
module digit_glyph_rom
    import doodle_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  bcd_digit_t               digit_i,
    input  logic [GLYPH_COORD_W-1:0] row_i,
    input  logic [GLYPH_COORD_W-1:0] col_i,
    input  logic                     visible_i,
    output rgb444_t                  color_o,
    output logic                     alpha_o
);

    localparam rgb444_t FG = {4'hF, 4'hF, 4'hF};

    rgb444_t color_q;
    logic    alpha_q;
    logic    lit_c;
    logic [6:0] seg_c;

    // Segment mask, bit 0 = a ... bit 6 = g; non-decimal codes are blank
    function automatic logic [6:0] seg_mask(input bcd_digit_t d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic in_rng(input logic [GLYPH_COORD_W-1:0] v,
                                    input int unsigned lo, input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

    always_comb begin
        seg_c = seg_mask(digit_i);
        lit_c = (seg_c[0] && in_rng(row_i, 0, 1)   && in_rng(col_i, 2, 10))
             || (seg_c[1] && in_rng(row_i, 1, 5)   && in_rng(col_i, 11, 12))
             || (seg_c[2] && in_rng(row_i, 6, 10)  && in_rng(col_i, 11, 12))
             || (seg_c[3] && in_rng(row_i, 10, 11) && in_rng(col_i, 2, 10))
             || (seg_c[4] && in_rng(row_i, 6, 10)  && in_rng(col_i, 0, 1))
             || (seg_c[5] && in_rng(row_i, 1, 5)   && in_rng(col_i, 0, 1))
             || (seg_c[6] && in_rng(row_i, 5, 6)   && in_rng(col_i, 2, 10));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            color_q <= '0;
            alpha_q <= 1'b1;
        end else begin
            color_q <= lit_c ? FG : '0;
            alpha_q <= ~(lit_c & visible_i);
        end
    end

    assign color_o = color_q;
    assign alpha_o = alpha_q;

endmodule

// File: rtl/score_display.sv
// BCD score/best-score keeper with a 2-stage N-digit glyph overlay renderer.
// Digit hit detection compares against each digit's left edge; no divider.
module score_display
    import doodle_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned LOCKOUT_FRAMES = 16,
    parameter int unsigned ORIGIN_X       = 266,
    parameter int unsigned ORIGIN_Y       = 22,
    parameter int unsigned DIGIT_WIDTH    = 13,
    parameter int unsigned DIGIT_HEIGHT   = 12,
    parameter int unsigned DIGIT_GAP      = 2,
    parameter int unsigned BLANK_LEADING  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic [1:0]              game_state,
    input  logic                    move_collision,
    input  logic                    show_best,
    input  logic [10:0]             beam_x,
    input  logic [9:0]              beam_y,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] best_bcd,
    output rgb444_t                 color,
    output logic                    is_transparent
);

    localparam int unsigned SCORE_W = 4 * NUM_DIGITS;
    localparam int unsigned LOCK_W  = $clog2(LOCKOUT_FRAMES);
    localparam int unsigned PITCH   = DIGIT_WIDTH + DIGIT_GAP;
    localparam logic [SCORE_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    logic [1:0]         prev_state_q, prev_state_d, cur_state_c;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;

    logic                     s1_valid_q, s1_hit_q, s1_blank_q;
    bcd_digit_t               s1_digit_q;
    logic [GLYPH_COORD_W-1:0] s1_row_q, s1_col_q;

    logic                     hit_c, blank_c;
    bcd_digit_t               digit_c;
    logic [GLYPH_COORD_W-1:0] row_c, col_c;
    logic [SCORE_W-1:0]       src_c;

    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // First differing digit from the MSD decides the magnitude
    function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic decided, gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                gt      = a[4*i +: 4] > b[4*i +: 4];
            end
        end
        return gt;
    endfunction

    assign cur_state_c = (game_state == 2'd3) ? GS_MENU : game_state;

    // Score, lockout and best-score next state
    always_comb begin
        prev_state_d = cur_state_c;
        score_d      = score_q;
        best_d       = best_q;
        lock_d       = lock_q;
        if (prev_state_q == GS_MENU && cur_state_c == GS_PLAY) begin
            score_d = '0;
            lock_d  = '0;
        end else if (cur_state_c == GS_PLAY && frame_tick) begin
            if (move_collision || lock_q != '0)
                lock_d = (lock_q == LOCK_W'(LOCKOUT_FRAMES - 1)) ? '0 : lock_q + LOCK_W'(1);
            if (move_collision && lock_q == '0 && score_q != ALL_NINES)
                score_d = bcd_inc(score_q);
            if (score_q == ALL_NINES)
                lock_d = '0;
        end
        if (prev_state_q == GS_PLAY && cur_state_c == GS_OVER && bcd_gt(score_q, best_q))
            best_d = score_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_state_q <= GS_MENU;
            score_q      <= '0;
            best_q       <= '0;
            lock_q       <= '0;
        end else begin
            prev_state_q <= prev_state_d;
            score_q      <= score_d;
            best_q       <= best_d;
            lock_q       <= lock_d;
        end
    end

    // Stage 1: locate the digit under the beam and its glyph coordinates
    always_comb begin
        int unsigned xk, bx, by;
        logic        zero_prefix, y_in;
        bcd_digit_t  d;
        src_c       = show_best ? best_q : score_q;
        bx          = 32'(beam_x);
        by          = 32'(beam_y);
        y_in        = (by >= ORIGIN_Y) && (by < ORIGIN_Y + DIGIT_HEIGHT);
        hit_c       = 1'b0;
        blank_c     = 1'b0;
        digit_c     = '0;
        col_c       = '0;
        row_c       = GLYPH_COORD_W'(by - ORIGIN_Y);
        zero_prefix = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            xk          = ORIGIN_X + k * PITCH;
            d           = src_c[4*(NUM_DIGITS-1-k) +: 4];
            zero_prefix = zero_prefix && (d == 4'd0);
            if (bx >= xk && bx < xk + DIGIT_WIDTH) begin
                hit_c   = y_in;
                digit_c = d;
                col_c   = GLYPH_COORD_W'(bx - xk);
                blank_c = (BLANK_LEADING != 0) && zero_prefix && (k < NUM_DIGITS - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_digit_q <= '0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
        end else begin
            s1_valid_q <= 1'b1;
            s1_hit_q   <= hit_c;
            s1_blank_q <= blank_c;
            s1_digit_q <= digit_c;
            s1_row_q   <= row_c;
            s1_col_q   <= col_c;
        end
    end

    // Stage 2: glyph lookup; ROM registers form the output stage
    digit_glyph_rom u_rom (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_i   (s1_digit_q),
        .row_i     (s1_row_q),
        .col_i     (s1_col_q),
        .visible_i (s1_valid_q & s1_hit_q & ~s1_blank_q),
        .color_o   (color),
        .alpha_o   (is_transparent)
    );

    assign score_bcd = score_q;
    assign best_bcd  = best_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: scoring, lockout, best capture, rendering, reset.
module tb_score_display;
    import doodle_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick, move_collision, show_best;
    logic [1:0]  game_state;
    logic [10:0] beam_x;
    logic [9:0]  beam_y;
    logic [15:0] score_bcd, best_bcd;
    rgb444_t     color;
    logic        is_transparent;

    logic        s_tick, s_coll;
    logic [1:0]  s_gs;
    logic [7:0]  s_score, s_best;
    rgb444_t     s_color;
    logic        s_transp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_display u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_state(game_state),
        .move_collision(move_collision), .show_best(show_best),
        .beam_x(beam_x), .beam_y(beam_y), .score_bcd(score_bcd), .best_bcd(best_bcd),
        .color(color), .is_transparent(is_transparent)
    );

    score_display #(.NUM_DIGITS(2), .LOCKOUT_FRAMES(2), .BLANK_LEADING(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .frame_tick(s_tick), .game_state(s_gs),
        .move_collision(s_coll), .show_best(show_best),
        .beam_x(beam_x), .beam_y(beam_y), .score_bcd(s_score), .best_bcd(s_best),
        .color(s_color), .is_transparent(s_transp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_state(input logic [1:0] gs);
        game_state = gs;
        @(posedge clk); #1;
    endtask

    task automatic new_game();
        set_state(GS_MENU);
        set_state(GS_PLAY);
    endtask

    task automatic ticks(input int n, input logic coll);
        repeat (n) begin
            frame_tick = 1'b1; move_collision = coll;
            @(posedge clk); #1;
        end
        frame_tick = 1'b0; move_collision = 1'b0;
    endtask

    task automatic sat_state(input logic [1:0] gs);
        s_gs = gs;
        @(posedge clk); #1;
    endtask

    task automatic sat_ticks(input int n);
        repeat (n) begin
            s_tick = 1'b1; s_coll = 1'b1;
            @(posedge clk); #1;
        end
        s_tick = 1'b0; s_coll = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        beam_x = 11'(x); beam_y = 10'(y);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic expect_opaque(input string tag);
        check(tag, 32'({color, is_transparent}), 32'h1FFE);
    endtask

    task automatic expect_clear(input string tag);
        check(tag, 32'(is_transparent), 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; move_collision = 1'b0; show_best = 1'b0;
        game_state = GS_MENU; beam_x = '0; beam_y = '0;
        s_tick = 1'b0; s_coll = 1'b0; s_gs = GS_MENU;
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_best",  32'(best_bcd),  32'h0);
        check("rst_transp", 32'(is_transparent), 32'h1);
        check("rst_color", 32'(color), 32'h0);
        rst_n = 1'b1;

        // Collision held 40 ticks: scores on ticks 1, 17, 33
        new_game();
        ticks(40, 1'b1);
        check("lockout_score", 32'(score_bcd), 32'h0003);
        check("lockout_count", 32'(u_dut.lock_q), 32'd8);

        new_game();
        ticks(2209, 1'b1);
        check("score_139", 32'(score_bcd), 32'h0139);
        set_state(GS_OVER);
        check("best_139", 32'(best_bcd), 32'h0139);
        ticks(20, 1'b1);
        check("over_hold", 32'(score_bcd), 32'h0139);

        new_game();
        check("menu_play_clear", 32'(score_bcd), 32'h0);
        ticks(1185, 1'b1);
        check("score_75", 32'(score_bcd), 32'h0075);
        set_state(GS_OVER);
        check("best_kept", 32'(best_bcd), 32'h0139);

        new_game();
        ticks(657, 1'b1);
        check("score_42", 32'(score_bcd), 32'h0042);
        set_state(GS_OVER);
        set_state(GS_MENU);

        // Rendering 0042: digits at x=266,281,296,311
        pix(271, 22); expect_clear("blank_d0");
        pix(286, 22); expect_clear("blank_d1");
        pix(296, 25); expect_opaque("d2_4_segf");
        pix(301, 22); expect_clear("d2_4_no_sega");
        pix(316, 22); expect_opaque("d3_2_sega");
        pix(311, 25); expect_clear("d3_2_no_segf");
        pix(279, 25); expect_clear("gap_col");
        pix(316, 21); expect_clear("above_box");

        new_game();
        pix(316, 22); expect_opaque("zero_d3_drawn");
        pix(301, 22); expect_clear("zero_d2_blank");

        show_best = 1'b1;
        pix(271, 22); expect_clear("best_d0_blank");
        pix(292, 25); expect_opaque("best_d1_1_segb");
        pix(286, 22); expect_clear("best_d1_1_no_sega");
        pix(301, 22); expect_opaque("best_d2_3_sega");
        pix(311, 25); expect_opaque("best_d3_9_segf");
        show_best = 1'b0;

        // Reset in the middle of a lockout window
        ticks(2, 1'b1);
        check("pre_rst_score", 32'(score_bcd), 32'h0001);
        pix(322, 25); expect_opaque("pre_rst_pixel");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_score", 32'(score_bcd), 32'h0);
        check("mid_rst_best",  32'(best_bcd),  32'h0);
        check("mid_rst_lock",  32'(u_dut.lock_q), 32'h0);
        check("mid_rst_transp", 32'(is_transparent), 32'h1);
        check("mid_rst_color", 32'(color), 32'h0);
        rst_n = 1'b1;

        // Saturation on the 2-digit instance
        sat_state(GS_MENU);
        sat_state(GS_PLAY);
        sat_ticks(195);
        check("sat_98", 32'(s_score), 32'h98);
        sat_ticks(4);
        check("sat_99_hold", 32'(s_score), 32'h99);
        check("sat_lock_zero", 32'(u_sat.lock_q), 32'h0);
        sat_state(GS_OVER);
        check("sat_best", 32'(s_best), 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
